sd_110_output_toggle: RTL and testbench
=======================================

Name: sd_110_output_toggle

Overview:
- Serial bit-stream sequence detector. Default pattern is "110", MSB first.
- Samples one input bit per clock and toggles a registered output each time the pattern completes; detection is overlapping.
- Used as a leaf block behind a serial data path, where downstream logic counts detections by watching output edges.

Parameters:
- PATTERN_LEN, 3, number of bits in the pattern; legal range 2..16.
- PATTERN, 3'b110, pattern to match. Bit [PATTERN_LEN-1] is the first bit received, bit [0] the last.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in   input  1  serial data bit; one bit consumed per rising edge.
- out  output 1  toggle output; inverts once per completed pattern match; registered.

Behaviour:
- Reset: when rst=1 at a rising edge, match state goes to 0 (nothing matched) and out goes to 0.
  - rst overrides any match on that edge; no toggle occurs.
  - Reset mid-sequence discards partial matches.
- State is the length k (0..PATTERN_LEN-1) of the longest proper prefix of PATTERN that equals a suffix of the bits received so far.
- Next-state rule, on each rising edge with rst=0, given state k and input bit b:
  - If b equals pattern bit number k (counting from the first bit), the candidate length is k+1.
  - Otherwise, fall back to the longest border (KMP failure function) that can be extended by b.
  - If the candidate length equals PATTERN_LEN, a match occurs: out <= ~out, and state becomes the failure-function value of the full pattern. This gives overlapping detection.
- The next-state/match table is fully determined by the parameters and is computed at elaboration, not at run time.
- Default (110) transitions:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1 (seen "1"): in=1 -> S2; in=0 -> S0.
  - S2 (seen "11"): in=1 -> S2; in=0 -> S0 and toggle out.
- Latency: out changes on the same rising edge that samples the final pattern bit; it is stable for the whole following cycle.
- out holds its value indefinitely when no match occurs.
- Back-to-back matches toggle out on each matching edge; out never pulses, it only toggles.
- No X propagation: state encoding is complete; unreachable encodings go to state 0.
- The state register is $clog2(PATTERN_LEN) bits wide, minimum 1.

Decomposition:
- Shared package sd_pkg holds:
  - the elaboration-time function that builds the next-state table from PATTERN/PATTERN_LEN;
  - the default pattern constant 3'b110.
- One sub-module is natural: sd_match_fsm, containing the state register and next-state table and emitting a one-cycle match strobe.
- The top level holds only the out toggle flop driven by that strobe.

Test Plan:
- Reset then idle: rst=1 for one edge, in=0 for 5 edges -> out=0 throughout.
- Basic match: after reset, drive in=1,1,0 on successive edges -> out goes 0->1 on the edge sampling the 0; out stays 1 while in=0 continues.
- Second match toggles back: continue with in=0,1,1,0 -> out 1->0 on the final 0 edge.
- Long run of ones: in=1,1,1,1,0 -> exactly one toggle, on the 0 edge; then in=1,0 -> no toggle.
- Reset mid-sequence: in=1,1, then rst=1 on the next edge with in=0 -> no toggle and out=0. After releasing rst, in=0 -> still no toggle.
- Parameter variant: PATTERN_LEN=4, PATTERN=4'b1010; stream 1,0,1,0,1,0 -> toggles on the 4th and 6th edges (overlap), giving out=1 then out=0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the serial sequence detector: default pattern and the
// elaboration-time builder for the next-state/match table.
package sd_pkg;

  localparam int              SD_MAX_LEN         = 16;
  localparam logic [2:0]      SD_DEFAULT_PATTERN = 3'b110;

  // Entry layout: [4] = match on this transition, [3:0] = next state.
  typedef logic [SD_MAX_LEN-1:0][1:0][4:0] sd_tbl_t;

  function automatic sd_tbl_t sd_build_tbl(input logic [SD_MAX_LEN-1:0] pat, input int len);
    sd_tbl_t tbl;
    int      fail [SD_MAX_LEN+1];
    logic    p    [SD_MAX_LEN];
    int      j;
    int      c;
    logic    bv;
    tbl = '0;
    for (int i = 0; i < SD_MAX_LEN; i++) begin
      p[i] = 1'b0;
      if (i < len) p[i] = pat[len-1-i];
    end
    for (int i = 0; i <= SD_MAX_LEN; i++) fail[i] = 0;
    // KMP failure function; the inner fallback loop is bounded so it stays a constant function.
    for (int i = 1; i < len; i++) begin
      j = fail[i];
      for (int t = 0; t < SD_MAX_LEN; t++)
        if (j > 0 && p[i] != p[j]) j = fail[j];
      if (p[i] == p[j]) j++;
      fail[i+1] = j;
    end
    for (int k = 0; k < len; k++) begin
      for (int b = 0; b < 2; b++) begin
        bv = 1'(b);
        j  = k;
        for (int t = 0; t < SD_MAX_LEN; t++)
          if (j > 0 && p[j] != bv) j = fail[j];
        c = (p[j] == bv) ? j + 1 : 0;
        if (c == len) tbl[k][b] = {1'b1, 4'(fail[len])};
        else          tbl[k][b] = {1'b0, 4'(c)};
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sd_match_fsm.sv
// Pattern-match state machine: holds the matched-prefix length and raises a
// combinational strobe during the cycle whose input bit completes the pattern.
module sd_match_fsm
  import sd_pkg::*;
#(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = SD_DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bit,
  output logic o_match
);

  localparam int      SW  = (PATTERN_LEN <= 2) ? 1 : $clog2(PATTERN_LEN);
  localparam sd_tbl_t TBL = sd_build_tbl(SD_MAX_LEN'(PATTERN), PATTERN_LEN);

  logic [SW-1:0] r_state;
  logic [3:0]    w_idx;
  logic [4:0]    w_ent;

  assign w_idx = 4'(r_state);

  // Encodings at or beyond PATTERN_LEN are unreachable; they fall back to state 0.
  always_comb begin
    w_ent = '0;
    if ({1'b0, w_idx} < 5'(PATTERN_LEN)) w_ent = TBL[w_idx][i_bit];
  end

  assign o_match = w_ent[4] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= '0;
    else     r_state <= SW'(w_ent[3:0]);
  end

endmodule

// File: rtl/sd_110_output_toggle.sv
// Serial sequence detector top: toggles a registered output once per
// (overlapping) pattern match reported by the match FSM.
module sd_110_output_toggle
  import sd_pkg::*;
#(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = SD_DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic w_match;

  sd_match_fsm #(
    .PATTERN_LEN (PATTERN_LEN),
    .PATTERN     (PATTERN)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .i_bit   (in),
    .o_match (w_match)
  );

  always_ff @(posedge clk) begin
    if (rst)          out <= 1'b0;
    else if (w_match) out <= ~out;
  end

endmodule

// File: tb/tb_sd_110_output_toggle.sv
// Directed bench: default 110 detector plus a 1010 variant for overlap.
module tb_sd_110_output_toggle;

  logic clk = 1'b0;
  logic rst_a, in_a, out_a;
  logic rst_b, in_b, out_b;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sd_110_output_toggle u_dut_a (
    .clk (clk), .rst (rst_a), .in (in_a), .out (out_a)
  );

  sd_110_output_toggle #(.PATTERN_LEN(4), .PATTERN(4'b1010)) u_dut_b (
    .clk (clk), .rst (rst_b), .in (in_b), .out (out_b)
  );

  task automatic tick_a(input logic b, input logic r);
    in_a = b; rst_a = r;
    @(posedge clk); #1;
  endtask

  task automatic tick_b(input logic b, input logic r);
    in_b = b; rst_b = r;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    rst_a = 1'b1; in_a = 1'b0; rst_b = 1'b1; in_b = 1'b0;
    @(negedge clk);

    // Reset then idle
    tick_a(0, 1); chk("reset", out_a, 0);
    for (int i = 0; i < 5; i++) begin tick_a(0, 0); chk("idle0", out_a, 0); end

    // Basic match 1,1,0
    tick_a(1, 0); chk("m1_b1", out_a, 0);
    tick_a(1, 0); chk("m1_b2", out_a, 0);
    tick_a(0, 0); chk("m1_b3", out_a, 1);
    tick_a(0, 0); chk("m1_hold", out_a, 1);

    // Second match 0,1,1,0 toggles back
    tick_a(0, 0); chk("m2_b1", out_a, 1);
    tick_a(1, 0); chk("m2_b2", out_a, 1);
    tick_a(1, 0); chk("m2_b3", out_a, 1);
    tick_a(0, 0); chk("m2_b4", out_a, 0);

    // Long run of ones then 0: one toggle; then 1,0 no toggle
    for (int i = 0; i < 4; i++) begin tick_a(1, 0); chk("ones", out_a, 0); end
    tick_a(0, 0); chk("ones_end", out_a, 1);
    tick_a(1, 0); chk("tail_1", out_a, 1);
    tick_a(0, 0); chk("tail_0", out_a, 1);

    // Reset mid-sequence overrides the completing 0
    tick_a(1, 0); chk("rmid_b1", out_a, 1);
    tick_a(1, 0); chk("rmid_b2", out_a, 1);
    tick_a(0, 1); chk("rmid_rst", out_a, 0);
    tick_a(0, 0); chk("rmid_after", out_a, 0);
    tick_a(1, 0); chk("rmid_1", out_a, 0);
    tick_a(0, 0); chk("rmid_partial", out_a, 0);

    // Fresh match after reset still works
    tick_a(1, 0); chk("post_b1", out_a, 0);
    tick_a(1, 0); chk("post_b2", out_a, 0);
    tick_a(1, 0); chk("post_b3", out_a, 0);
    tick_a(0, 0); chk("post_b4", out_a, 1);

    // Variant 1010 with overlap
    tick_b(0, 1); chk("v_reset", out_b, 0);
    tick_b(1, 0); chk("v_e1", out_b, 0);
    tick_b(0, 0); chk("v_e2", out_b, 0);
    tick_b(1, 0); chk("v_e3", out_b, 0);
    tick_b(0, 0); chk("v_e4", out_b, 1);
    tick_b(1, 0); chk("v_e5", out_b, 1);
    tick_b(0, 0); chk("v_e6", out_b, 0);
    tick_b(0, 0); chk("v_e7", out_b, 0);
    tick_b(0, 0); chk("v_e8", out_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
